// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback writer.
//   XLEN        - integer datapath width
//   REG_ADDR_W  - register-file address width
//   NUM_REGS    - number of architectural integer registers
//   wb_entry_t  - one buffered long-latency result (destination + data)
package wb_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding long-latency results until the register
// file write port is free.
// Ports:
//   clk, rst        - clock, synchronous active-low reset
//   push, push_entry- enqueue request and entry (ignored when full)
//   pop             - dequeue request (ignored when empty)
//   head            - entry at the read pointer (valid when !empty)
//   full, empty     - occupancy flags
//   count           - current occupancy, 0..DEPTH
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  wb_entry_t                push_entry,
    input  logic                     pop,
    output wb_entry_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    wb_entry_t       mem_q [DEPTH];
    wb_entry_t       mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            do_push;
    logic            do_pop;

    always_comb begin
        full    = (count_q == (AW+1)'(DEPTH));
        empty   = (count_q == '0);
        count   = count_q;
        head    = mem_q[rd_ptr_q];
        do_push = push & ~full;
        do_pop  = pop & ~empty;

        mem_d = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_entry;
        end

        // DEPTH is a power of two, so the pointers wrap by natural overflow.
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; occupancy state alone defines validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/wb_writer.sv
// Writeback writer: drives the single register-file write port, merging
// single-cycle ALU results with buffered long-latency (load/divide) results,
// and tracks in-flight long-latency destinations for hazard detection.
// Ports:
//   clk, rst                     - clock, synchronous active-low reset
//   alu_valid/alu_rd/alu_data    - ALU result, always accepted, highest priority
//   lsu_valid/lsu_ready/lsu_rd/lsu_data - long-latency result handshake
//   issue_valid/issue_long/issue_rd, rs1, rs2 - instruction at issue
//   hazard                       - issuing instruction touches a pending register
//   rd/write_data/reg_write      - registered register-file write port
//   fifo_count                   - long-latency buffer occupancy
module wb_writer #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    input  logic [4:0]                    alu_rd,
    input  logic [XLEN-1:0]               alu_data,
    input  logic                          lsu_valid,
    output logic                          lsu_ready,
    input  logic [4:0]                    lsu_rd,
    input  logic [XLEN-1:0]               lsu_data,
    input  logic                          issue_valid,
    input  logic                          issue_long,
    input  logic [4:0]                    issue_rd,
    input  logic [4:0]                    rs1,
    input  logic [4:0]                    rs2,
    output logic                          hazard,
    output logic [4:0]                    rd,
    output logic [XLEN-1:0]               write_data,
    output logic                          reg_write,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    import wb_pkg::*;

    wb_entry_t         push_entry;
    wb_entry_t         fifo_head;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;

    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   write_data_q, write_data_d;
    logic              reg_write_q, reg_write_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    always_comb begin
        // Readiness deliberately ignores a same-cycle pop to keep the
        // handshake off the ALU arbitration path.
        lsu_ready  = rst & ~fifo_full;
        fifo_push  = lsu_valid & lsu_ready;
        fifo_pop   = ~alu_valid & ~fifo_empty;
        push_entry = '{rd: lsu_rd, data: lsu_data};
    end

    // Write-port arbitration: ALU first, FIFO head only when the ALU is idle.
    always_comb begin
        rd_d         = rd_q;
        write_data_d = write_data_q;
        reg_write_d  = 1'b0;
        if (alu_valid) begin
            rd_d         = alu_rd;
            write_data_d = alu_data;
            reg_write_d  = (alu_rd != 5'd0);
        end else if (!fifo_empty) begin
            rd_d         = fifo_head.rd;
            write_data_d = fifo_head.data;
            reg_write_d  = (fifo_head.rd != 5'd0);
        end
    end

    // Scoreboard: the set is applied after the clear so a same-cycle
    // issue to a retiring register leaves it pending.
    always_comb begin
        pending_d = pending_q;
        if (fifo_pop && fifo_head.rd != 5'd0) begin
            pending_d[fifo_head.rd] = 1'b0;
        end
        if (issue_valid && issue_long && issue_rd != 5'd0) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        hazard = rst & (((rs1      != 5'd0) & pending_q[rs1]) |
                        ((rs2      != 5'd0) & pending_q[rs2]) |
                        ((issue_rd != 5'd0) & pending_q[issue_rd]));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_q         <= '0;
            write_data_q <= '0;
            reg_write_q  <= 1'b0;
            pending_q    <= '0;
        end else begin
            rd_q         <= rd_d;
            write_data_q <= write_data_d;
            reg_write_q  <= reg_write_d;
            pending_q    <= pending_d;
        end
    end

    assign rd         = rd_q;
    assign write_data = write_data_q;
    assign reg_write  = reg_write_q;
endmodule

// File: tb/tb_wb_writer.sv
module tb_wb_writer;
    localparam int XLEN       = 32;
    localparam int FIFO_DEPTH = 2;

    logic              clk;
    logic              rst;
    logic              alu_valid;
    logic [4:0]        alu_rd;
    logic [XLEN-1:0]   alu_data;
    logic              lsu_valid;
    logic              lsu_ready;
    logic [4:0]        lsu_rd;
    logic [XLEN-1:0]   lsu_data;
    logic              issue_valid;
    logic              issue_long;
    logic [4:0]        issue_rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic              hazard;
    logic [4:0]        rd;
    logic [XLEN-1:0]   write_data;
    logic              reg_write;
    logic [1:0]        fifo_count;

    int                nvec;
    int                nerr;
    logic [31:0]       sb_model;

    wb_writer #(
        .XLEN       (XLEN),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .issue_valid (issue_valid),
        .issue_long  (issue_long),
        .issue_rd    (issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .hazard      (hazard),
        .rd          (rd),
        .write_data  (write_data),
        .reg_write   (reg_write),
        .fifo_count  (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Protocol monitor: the stimulus must never issue into a hazard or
    // send an ALU result to a register with a long op in flight.
    always @(posedge clk) begin
        if (rst) begin
            if (issue_valid && hazard) begin
                nerr++;
                $display("FAIL issue_on_hazard: issue_rd=%0d rs1=%0d rs2=%0d issued while hazard=1",
                         issue_rd, rs1, rs2);
            end
            if (alu_valid && alu_rd != 5'd0 && sb_model[alu_rd]) begin
                nerr++;
                $display("FAIL alu_to_pending: alu_rd=%0d is pending", alu_rd);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        alu_valid   = 1'b0;
        alu_rd      = '0;
        alu_data    = '0;
        lsu_valid   = 1'b0;
        lsu_rd      = '0;
        lsu_data    = '0;
        issue_valid = 1'b0;
        issue_long  = 1'b0;
        issue_rd    = '0;
        rs1         = '0;
        rs2         = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            alu_valid   = 1'($urandom_range(0, 1));
            alu_rd      = 5'($urandom_range(0, 31));
            alu_data    = $urandom;
            lsu_valid   = 1'($urandom_range(0, 1));
            lsu_rd      = 5'($urandom_range(0, 31));
            lsu_data    = $urandom;
            issue_valid = 1'($urandom_range(0, 1));
            issue_long  = 1'($urandom_range(0, 1));
            issue_rd    = 5'($urandom_range(1, 31));
            rs1         = 5'($urandom_range(1, 31));
            rs2         = 5'($urandom_range(1, 31));
            tick();
        end
        nvec++; if (reg_write !== 1'b0) begin nerr++; $display("FAIL reset_reg_write: got %0b want 0", reg_write); end
        nvec++; if (rd !== 5'd0) begin nerr++; $display("FAIL reset_rd: got %0d want 0", rd); end
        nvec++; if (write_data !== 32'h0) begin nerr++; $display("FAIL reset_write_data: got %08h want 00000000", write_data); end
        nvec++; if (lsu_ready !== 1'b0) begin nerr++; $display("FAIL reset_lsu_ready: got %0b want 0", lsu_ready); end
        nvec++; if (fifo_count !== 2'd0) begin nerr++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count); end
        nvec++; if (hazard !== 1'b0) begin nerr++; $display("FAIL reset_hazard: got %0b want 0", hazard); end
        drive_idle();
        rst = 1'b1;
        #1;
        nvec++; if (lsu_ready !== 1'b1) begin nerr++; $display("FAIL release_lsu_ready: got %0b want 1", lsu_ready); end
        tick();
        nvec++; if (reg_write !== 1'b0) begin nerr++; $display("FAIL release_reg_write: got %0b want 0", reg_write); end
    endtask

    task automatic test_alu_path();
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 32'hDEADBEEF;
        tick();
        alu_valid = 1'b0;
        rs1       = 5'd5;
        #1;
        nvec++; if (reg_write !== 1'b1) begin nerr++; $display("FAIL alu_reg_write: got %0b want 1", reg_write); end
        nvec++; if (rd !== 5'd5) begin nerr++; $display("FAIL alu_rd: got %0d want 5", rd); end
        nvec++; if (write_data !== 32'hDEADBEEF) begin nerr++; $display("FAIL alu_data: got %08h want deadbeef", write_data); end
        nvec++; if (hazard !== 1'b0) begin nerr++; $display("FAIL alu_no_pending: hazard got %0b want 0", hazard); end
        rs1 = 5'd0;
        tick();
        nvec++; if (reg_write !== 1'b0) begin nerr++; $display("FAIL alu_one_shot: reg_write got %0b want 0", reg_write); end
    endtask

    task automatic test_scoreboard();
        issue_valid = 1'b1;
        issue_long  = 1'b1;
        issue_rd    = 5'd7;
        #1;
        nvec++; if (hazard !== 1'b0) begin nerr++; $display("FAIL sb_set_not_visible: hazard got %0b want 0", hazard); end
        tick();
        sb_model[7] = 1'b1;
        issue_valid = 1'b0;
        issue_long  = 1'b0;
        issue_rd    = 5'd0;
        rs1         = 5'd7;
        #1;
        nvec++; if (hazard !== 1'b1) begin nerr++; $display("FAIL sb_hazard_rs1: got %0b want 1", hazard); end
        rs1 = 5'd0;
        rs2 = 5'd7;
        #1;
        nvec++; if (hazard !== 1'b1) begin nerr++; $display("FAIL sb_hazard_rs2: got %0b want 1", hazard); end
        rs2      = 5'd0;
        issue_rd = 5'd7;
        #1;
        nvec++; if (hazard !== 1'b1) begin nerr++; $display("FAIL sb_hazard_waw: got %0b want 1", hazard); end
        issue_rd  = 5'd0;
        rs1       = 5'd7;
        lsu_valid = 1'b1;
        lsu_rd    = 5'd7;
        lsu_data  = 32'h12345678;
        #1;
        nvec++; if (lsu_ready !== 1'b1) begin nerr++; $display("FAIL sb_lsu_ready: got %0b want 1", lsu_ready); end
        tick();
        lsu_valid = 1'b0;
        #1;
        nvec++; if (fifo_count !== 2'd1) begin nerr++; $display("FAIL sb_fifo_count: got %0d want 1", fifo_count); end
        nvec++; if (reg_write !== 1'b0) begin nerr++; $display("FAIL sb_no_early_write: got %0b want 0", reg_write); end
        nvec++; if (hazard !== 1'b1) begin nerr++; $display("FAIL sb_still_pending: hazard got %0b want 1", hazard); end
        tick();
        sb_model[7] = 1'b0;
        nvec++; if (reg_write !== 1'b1) begin nerr++; $display("FAIL sb_write_en: got %0b want 1", reg_write); end
        nvec++; if (rd !== 5'd7) begin nerr++; $display("FAIL sb_write_rd: got %0d want 7", rd); end
        nvec++; if (write_data !== 32'h12345678) begin nerr++; $display("FAIL sb_write_data: got %08h want 12345678", write_data); end
        nvec++; if (hazard !== 1'b0) begin nerr++; $display("FAIL sb_cleared: hazard got %0b want 0", hazard); end
        nvec++; if (fifo_count !== 2'd0) begin nerr++; $display("FAIL sb_drained: fifo_count got %0d want 0", fifo_count); end
        rs1 = 5'd0;
    endtask

    task automatic test_back_pressure();
        alu_valid = 1'b1;
        alu_rd    = 5'd3;
        alu_data  = 32'hA5A5_0003;
        lsu_valid = 1'b1;
        lsu_rd    = 5'd10;
        lsu_data  = 32'h0000_AAAA;
        #1;
        nvec++; if (lsu_ready !== 1'b1) begin nerr++; $display("FAIL bp_ready_empty: got %0b want 1", lsu_ready); end
        tick();
        lsu_rd   = 5'd11;
        lsu_data = 32'h0000_BBBB;
        #1;
        nvec++; if (fifo_count !== 2'd1) begin nerr++; $display("FAIL bp_count1: got %0d want 1", fifo_count); end
        tick();
        lsu_rd   = 5'd12;
        lsu_data = 32'h0000_CCCC;
        #1;
        nvec++; if (fifo_count !== 2'd2) begin nerr++; $display("FAIL bp_count2: got %0d want 2", fifo_count); end
        nvec++; if (lsu_ready !== 1'b0) begin nerr++; $display("FAIL bp_full_ready: got %0b want 0", lsu_ready); end
        tick();
        nvec++; if (fifo_count !== 2'd2) begin nerr++; $display("FAIL bp_no_overflow: got %0d want 2", fifo_count); end
        nvec++; if (rd !== 5'd3 || write_data !== 32'hA5A5_0003 || reg_write !== 1'b1) begin
            nerr++; $display("FAIL bp_alu_wins: got rd=%0d data=%08h we=%0b want rd=3 data=a5a50003 we=1", rd, write_data, reg_write);
        end
        alu_valid = 1'b0;
        #1;
        nvec++; if (lsu_ready !== 1'b0) begin nerr++; $display("FAIL bp_ready_ignores_pop: got %0b want 0", lsu_ready); end
        tick();
        nvec++; if (rd !== 5'd10 || write_data !== 32'h0000_AAAA || reg_write !== 1'b1) begin
            nerr++; $display("FAIL bp_drain0: got rd=%0d data=%08h we=%0b want rd=10 data=0000aaaa we=1", rd, write_data, reg_write);
        end
        nvec++; if (fifo_count !== 2'd1) begin nerr++; $display("FAIL bp_drain0_count: got %0d want 1", fifo_count); end
        nvec++; if (lsu_ready !== 1'b1) begin nerr++; $display("FAIL bp_ready_again: got %0b want 1", lsu_ready); end
        tick();
        lsu_valid = 1'b0;
        nvec++; if (rd !== 5'd11 || write_data !== 32'h0000_BBBB || reg_write !== 1'b1) begin
            nerr++; $display("FAIL bp_drain1: got rd=%0d data=%08h we=%0b want rd=11 data=0000bbbb we=1", rd, write_data, reg_write);
        end
        nvec++; if (fifo_count !== 2'd1) begin nerr++; $display("FAIL bp_push_pop_count: got %0d want 1", fifo_count); end
        tick();
        nvec++; if (rd !== 5'd12 || write_data !== 32'h0000_CCCC || reg_write !== 1'b1) begin
            nerr++; $display("FAIL bp_drain2: got rd=%0d data=%08h we=%0b want rd=12 data=0000cccc we=1", rd, write_data, reg_write);
        end
        tick();
        nvec++; if (reg_write !== 1'b0 || fifo_count !== 2'd0) begin
            nerr++; $display("FAIL bp_idle: got we=%0b count=%0d want we=0 count=0", reg_write, fifo_count);
        end
    endtask

    task automatic test_x0();
        alu_valid = 1'b1;
        alu_rd    = 5'd0;
        alu_data  = 32'hFFFF_FFFF;
        tick();
        alu_valid = 1'b0;
        nvec++; if (reg_write !== 1'b0) begin nerr++; $display("FAIL x0_alu_we: got %0b want 0", reg_write); end
        lsu_valid = 1'b1;
        lsu_rd    = 5'd0;
        lsu_data  = 32'h5555_5555;
        tick();
        lsu_valid = 1'b0;
        nvec++; if (fifo_count !== 2'd1) begin nerr++; $display("FAIL x0_lsu_push: count got %0d want 1", fifo_count); end
        tick();
        nvec++; if (reg_write !== 1'b0) begin nerr++; $display("FAIL x0_lsu_we: got %0b want 0", reg_write); end
        nvec++; if (fifo_count !== 2'd0) begin nerr++; $display("FAIL x0_lsu_popped: count got %0d want 0", fifo_count); end
        issue_valid = 1'b1;
        issue_long  = 1'b1;
        issue_rd    = 5'd0;
        tick();
        issue_valid = 1'b0;
        issue_long  = 1'b0;
        rs1         = 5'd0;
        #1;
        nvec++; if (hazard !== 1'b0) begin nerr++; $display("FAIL x0_hazard: got %0b want 0", hazard); end
    endtask

    task automatic test_set_wins();
        // rd=9 result arrives without a prior long issue, so issuing rd=9
        // while it retires is legal and exercises the set/clear collision.
        lsu_valid = 1'b1;
        lsu_rd    = 5'd9;
        lsu_data  = 32'h0000_0909;
        alu_valid = 1'b1;
        alu_rd    = 5'd2;
        alu_data  = 32'h2;
        tick();
        lsu_valid = 1'b0;
        alu_valid = 1'b0;
        issue_valid = 1'b1;
        issue_long  = 1'b1;
        issue_rd    = 5'd9;
        #1;
        nvec++; if (hazard !== 1'b0) begin nerr++; $display("FAIL sw_pre_hazard: got %0b want 0", hazard); end
        tick();
        sb_model[9] = 1'b1;
        issue_valid = 1'b0;
        issue_long  = 1'b0;
        issue_rd    = 5'd0;
        rs1         = 5'd9;
        #1;
        nvec++; if (rd !== 5'd9 || reg_write !== 1'b1) begin
            nerr++; $display("FAIL sw_retire: got rd=%0d we=%0b want rd=9 we=1", rd, reg_write);
        end
        nvec++; if (hazard !== 1'b1) begin nerr++; $display("FAIL sw_set_wins: hazard got %0b want 1", hazard); end
        rs1 = 5'd0;
    endtask

    task automatic test_reset_mid();
        alu_valid = 1'b1;
        alu_rd    = 5'd4;
        alu_data  = 32'h4444;
        lsu_valid = 1'b1;
        lsu_rd    = 5'd20;
        lsu_data  = 32'h2020;
        tick();
        lsu_rd    = 5'd21;
        lsu_data  = 32'h2121;
        tick();
        lsu_valid = 1'b0;
        #1;
        nvec++; if (fifo_count !== 2'd2) begin nerr++; $display("FAIL rm_full: count got %0d want 2", fifo_count); end
        rst       = 1'b0;
        alu_valid = 1'b0;
        rs1       = 5'd9;
        tick();
        nvec++; if (fifo_count !== 2'd0) begin nerr++; $display("FAIL rm_count: got %0d want 0", fifo_count); end
        nvec++; if (reg_write !== 1'b0) begin nerr++; $display("FAIL rm_we_in_reset: got %0b want 0", reg_write); end
        nvec++; if (hazard !== 1'b0) begin nerr++; $display("FAIL rm_hazard_in_reset: got %0b want 0", hazard); end
        rst = 1'b1;
        sb_model = '0;
        #1;
        nvec++; if (hazard !== 1'b0) begin nerr++; $display("FAIL rm_pending_cleared: hazard got %0b want 0", hazard); end
        for (int i = 0; i < 3; i++) begin
            tick();
            nvec++; if (reg_write !== 1'b0 || fifo_count !== 2'd0) begin
                nerr++; $display("FAIL rm_no_writes[%0d]: got we=%0b count=%0d want we=0 count=0", i, reg_write, fifo_count);
            end
        end
        rs1 = 5'd0;
    endtask

    initial begin
        nvec     = 0;
        nerr     = 0;
        sb_model = '0;
        rst      = 1'b0;
        drive_idle();
        test_reset();
        test_alu_path();
        test_scoreboard();
        test_back_pressure();
        test_x0();
        test_set_wins();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
